// File: rtl/e_box_inv.sv
// e_box_inv: inverse of the DES E expansion.
// Collects eight 6-bit groups of a 48-bit expanded word, recovers the
// 32-bit half-block from the four middle bits of each group, and checks that
// the duplicated edge bits of every group agree with their neighbours.
// A completed block is presented with a valid/ready handshake; while it is
// pending no further groups are accepted.
module e_box_inv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic [0:5]  in_group,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] R,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  // Two-state controller: gathering groups, or holding a finished block.
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  localparam logic [2:0] LAST_SLOT = 3'd7;

  logic [0:0]  state_r;
  logic [2:0]  cnt_r;
  logic [0:5]  grp_r [0:6];

  logic        accept_s;
  logic        complete_s;
  logic [2:0]  slot_s;
  logic [0:47] er_s;
  logic [0:31] r_nxt_s;
  logic        err_nxt_s;

  // Pull the four middle bits of every group into the half-block.
  function automatic logic [0:31] er_to_r(input logic [0:47] er);
    logic [0:31] r;
    r = 32'h0000_0000;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = er[6*k+1 +: 4];
    end
    return r;
  endfunction

  // Edge-bit consistency: bit 0 of group k duplicates bit 4 of group k-1,
  // bit 5 of group k duplicates bit 1 of group k+1 (indices wrap mod 8).
  function automatic logic er_edge_err(input logic [0:47] er);
    logic err;
    int   prv;
    int   nxt;
    err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      prv = (k + 7) % 8;
      nxt = (k + 1) % 8;
      err = err | (er[6*k]     ^ er[6*prv + 4]);
      err = err | (er[6*k + 5] ^ er[6*nxt + 1]);
    end
    return err;
  endfunction

  assign in_ready  = (state_r == COLLECT);
  assign out_valid = (state_r == HOLD);

  // Slot selection and acceptance: in_first always restarts at slot 0,
  // so an in_first group can never be the completing slot-7 group.
  always_comb begin
    accept_s = in_valid && (state_r == COLLECT);
    if (in_first) begin
      slot_s = 3'd0;
    end else begin
      slot_s = cnt_r;
    end
    complete_s = accept_s && (slot_s == LAST_SLOT);
  end

  // Assemble the full expanded word: stored slots 0..6 plus the incoming
  // group, which is slot 7 whenever the block completes this cycle.
  always_comb begin
    er_s = 48'h0000_0000_0000;
    for (int k = 0; k < 7; k++) begin
      er_s[6*k +: 6] = grp_r[k];
    end
    er_s[42 +: 6] = in_group;
    r_nxt_s   = er_to_r(er_s);
    err_nxt_s = er_edge_err(er_s);
  end

  // Controller state and slot counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      cnt_r   <= 3'd0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            cnt_r <= slot_s + 3'd1;
          end
          if (complete_s) begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r <= COLLECT;
          end
        end
        default: begin
          state_r <= COLLECT;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

  // Group storage for slots 0..6; slot 7 is consumed directly from the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 7; k++) begin
        grp_r[k] <= 6'b000000;
      end
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (accept_s && (slot_s == 3'(k))) begin
          grp_r[k] <= in_group;
        end
      end
    end
  end

  // Output registers: captured once on completion, held until the next block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R       <= 32'h0000_0000;
      out_err <= 1'b0;
    end else begin
      if (complete_s) begin
        R       <= r_nxt_s;
        out_err <= err_nxt_s;
      end
    end
  end

  // Saturating error counter, stepped together with the rising out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else begin
      if (complete_s && err_nxt_s && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
